// File: rtl/can_rx_field_sequencer_if.sv
// Bus between the bit destuffer / protocol FSM (master) and the receive field sequencer (slave).
// Signal names keep their direction suffix as seen from the sequencer.
interface can_rx_field_sequencer_if;
  logic        sample_point_i;
  logic        sampled_bit_i;
  logic        fdf_i;
  logic        rtr_i;
  logic        is_dlc_i;
  logic        is_data_i;
  logic        is_stuff_count_i;
  logic        is_crc_i;
  logic        is_error_frame_i;

  logic        go_rx_data_o;
  logic        go_rx_stuff_count_o;
  logic        go_rx_crc_o;
  logic        go_rx_crc_lim_o;
  logic [3:0]  dlc_o;
  logic [6:0]  data_len_o;
  logic [7:0]  data_byte_o;
  logic [5:0]  data_byte_idx_o;
  logic        data_byte_valid_o;
  logic [2:0]  stuff_count_o;
  logic        stuff_parity_err_o;
  logic [20:0] crc_rx_o;
  logic [4:0]  crc_len_o;

  modport master (
    output sample_point_i, sampled_bit_i, fdf_i, rtr_i,
    output is_dlc_i, is_data_i, is_stuff_count_i, is_crc_i, is_error_frame_i,
    input  go_rx_data_o, go_rx_stuff_count_o, go_rx_crc_o, go_rx_crc_lim_o,
    input  dlc_o, data_len_o, data_byte_o, data_byte_idx_o, data_byte_valid_o,
    input  stuff_count_o, stuff_parity_err_o, crc_rx_o, crc_len_o
  );

  modport slave (
    input  sample_point_i, sampled_bit_i, fdf_i, rtr_i,
    input  is_dlc_i, is_data_i, is_stuff_count_i, is_crc_i, is_error_frame_i,
    output go_rx_data_o, go_rx_stuff_count_o, go_rx_crc_o, go_rx_crc_lim_o,
    output dlc_o, data_len_o, data_byte_o, data_byte_idx_o, data_byte_valid_o,
    output stuff_count_o, stuff_parity_err_o, crc_rx_o, crc_len_o
  );
endinterface

// File: rtl/can_rx_field_sequencer.sv
// Receive-side field sequencer for the DLC, data, stuff-count and CRC fields of CAN / CAN FD.
// Counts destuffed bits per field, assembles field contents and pulses the FSM transitions.
module can_rx_field_sequencer #(
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  can_rx_field_sequencer_if.slave        bus
);

  localparam int unsigned CntW = $clog2(MAX_BYTES * 8 + 1);
  typedef logic [CntW-1:0] cnt_t;

  localparam logic [3:0] FieldDlc   = 4'b1000;
  localparam logic [3:0] FieldData  = 4'b0100;
  localparam logic [3:0] FieldStuff = 4'b0010;
  localparam logic [3:0] FieldCrc   = 4'b0001;

  function automatic logic [6:0] dlc_to_len(input logic fd, input logic rtr,
                                            input logic [3:0] dlc);
    logic [6:0] len;
    if (!fd) begin
      if (rtr)             len = 7'd0;
      else if (dlc > 4'd8) len = 7'd8;
      else                 len = {3'b000, dlc};
    end else begin
      unique case (dlc)
        4'd9:    len = 7'd12;
        4'd10:   len = 7'd16;
        4'd11:   len = 7'd20;
        4'd12:   len = 7'd24;
        4'd13:   len = 7'd32;
        4'd14:   len = 7'd48;
        4'd15:   len = 7'd64;
        default: len = {3'b000, dlc};
      endcase
    end
    return len;
  endfunction

  logic [3:0]  field_sel, field_q, field_d;
  logic        field_valid, accept, rx_bit;
  cnt_t        bit_cnt_q, bit_cnt_d, cnt_base, cnt_next, data_bits;

  logic [3:0]  dlc_q, dlc_d, dlc_shift;
  logic [6:0]  data_len_q, data_len_d, len_dec;
  logic [6:0]  byte_sr_q, byte_sr_d;
  logic [7:0]  data_byte_q, data_byte_d, byte_shift;
  logic [5:0]  data_byte_idx_q, data_byte_idx_d;
  logic        data_byte_valid_q, data_byte_valid_d;
  logic [2:0]  stuff_count_q, stuff_count_d;
  logic        parity_acc_q, parity_acc_d;
  logic        stuff_parity_err_q, stuff_parity_err_d;
  logic [20:0] crc_rx_q, crc_rx_d;
  logic [4:0]  crc_len_q, crc_len_d;
  logic        go_rx_data_q, go_rx_data_d;
  logic        go_rx_stuff_count_q, go_rx_stuff_count_d;
  logic        go_rx_crc_q, go_rx_crc_d;
  logic        go_rx_crc_lim_q, go_rx_crc_lim_d;

  assign field_sel   = {bus.is_dlc_i, bus.is_data_i, bus.is_stuff_count_i, bus.is_crc_i};
  assign field_valid = $onehot(field_sel) && !bus.is_error_frame_i;
  assign accept      = bus.sample_point_i && field_valid;
  assign rx_bit      = bus.sampled_bit_i;

  // A field entered afresh (or re-entered after a drop) always starts counting from zero.
  assign cnt_base  = (field_valid && (field_sel == field_q)) ? bit_cnt_q : '0;
  assign cnt_next  = cnt_base + cnt_t'(1);
  assign data_bits = cnt_t'({data_len_q, 3'b000});

  assign dlc_shift  = {dlc_q[2:0], rx_bit};
  assign byte_shift = {byte_sr_q, rx_bit};
  assign len_dec    = dlc_to_len(bus.fdf_i, bus.rtr_i, dlc_shift);

  always_comb begin
    field_d             = field_sel;
    bit_cnt_d           = field_valid ? cnt_base : '0;
    dlc_d               = dlc_q;
    data_len_d          = data_len_q;
    byte_sr_d           = byte_sr_q;
    data_byte_d         = data_byte_q;
    data_byte_idx_d     = data_byte_idx_q;
    data_byte_valid_d   = 1'b0;
    stuff_count_d       = stuff_count_q;
    parity_acc_d        = parity_acc_q;
    stuff_parity_err_d  = stuff_parity_err_q;
    crc_rx_d            = crc_rx_q;
    crc_len_d           = crc_len_q;
    go_rx_data_d        = 1'b0;
    go_rx_stuff_count_d = 1'b0;
    go_rx_crc_d         = 1'b0;
    go_rx_crc_lim_d     = 1'b0;

    if (bus.is_error_frame_i) begin
      stuff_parity_err_d = 1'b0;
    end

    if (accept) begin
      bit_cnt_d = cnt_next;
      unique case (field_sel)
        FieldDlc: begin
          dlc_d = dlc_shift;
          if (cnt_base == '0) begin
            crc_rx_d           = '0;
            stuff_parity_err_d = 1'b0;
          end
          if (cnt_next == cnt_t'(4)) begin
            bit_cnt_d  = '0;
            data_len_d = len_dec;
            if (!bus.fdf_i)              crc_len_d = 5'd15;
            else if (len_dec <= 7'd16)   crc_len_d = 5'd17;
            else                         crc_len_d = 5'd21;
            if (len_dec != 7'd0)         go_rx_data_d        = 1'b1;
            else if (bus.fdf_i)          go_rx_stuff_count_d = 1'b1;
            else                         go_rx_crc_d         = 1'b1;
          end
        end
        FieldData: begin
          byte_sr_d = byte_shift[6:0];
          if (cnt_next[2:0] == 3'b000) begin
            data_byte_d       = byte_shift;
            data_byte_idx_d   = 6'(cnt_base >> 3);
            data_byte_valid_d = 1'b1;
          end
          if (cnt_next == data_bits) begin
            bit_cnt_d = '0;
            if (bus.fdf_i) go_rx_stuff_count_d = 1'b1;
            else           go_rx_crc_d         = 1'b1;
          end
        end
        FieldStuff: begin
          parity_acc_d = (cnt_base == '0) ? rx_bit : (parity_acc_q ^ rx_bit);
          if (cnt_next <= cnt_t'(3)) begin
            stuff_count_d = {stuff_count_q[1:0], rx_bit};
          end
          if (cnt_next == cnt_t'(4)) begin
            bit_cnt_d = '0;
            if (parity_acc_q ^ rx_bit) stuff_parity_err_d = 1'b1;
            go_rx_crc_d = 1'b1;
          end
        end
        FieldCrc: begin
          // Cleared at DLC start, so shorter CRCs leave the upper bits zero.
          crc_rx_d = {crc_rx_q[19:0], rx_bit};
          if (cnt_next == cnt_t'(crc_len_q)) begin
            bit_cnt_d       = '0;
            go_rx_crc_lim_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      field_q             <= '0;
      bit_cnt_q           <= '0;
      dlc_q               <= '0;
      data_len_q          <= '0;
      byte_sr_q           <= '0;
      data_byte_q         <= '0;
      data_byte_idx_q     <= '0;
      data_byte_valid_q   <= 1'b0;
      stuff_count_q       <= '0;
      parity_acc_q        <= 1'b0;
      stuff_parity_err_q  <= 1'b0;
      crc_rx_q            <= '0;
      crc_len_q           <= '0;
      go_rx_data_q        <= 1'b0;
      go_rx_stuff_count_q <= 1'b0;
      go_rx_crc_q         <= 1'b0;
      go_rx_crc_lim_q     <= 1'b0;
    end else begin
      field_q             <= field_d;
      bit_cnt_q           <= bit_cnt_d;
      dlc_q               <= dlc_d;
      data_len_q          <= data_len_d;
      byte_sr_q           <= byte_sr_d;
      data_byte_q         <= data_byte_d;
      data_byte_idx_q     <= data_byte_idx_d;
      data_byte_valid_q   <= data_byte_valid_d;
      stuff_count_q       <= stuff_count_d;
      parity_acc_q        <= parity_acc_d;
      stuff_parity_err_q  <= stuff_parity_err_d;
      crc_rx_q            <= crc_rx_d;
      crc_len_q           <= crc_len_d;
      go_rx_data_q        <= go_rx_data_d;
      go_rx_stuff_count_q <= go_rx_stuff_count_d;
      go_rx_crc_q         <= go_rx_crc_d;
      go_rx_crc_lim_q     <= go_rx_crc_lim_d;
    end
  end

  assign bus.go_rx_data_o        = go_rx_data_q;
  assign bus.go_rx_stuff_count_o = go_rx_stuff_count_q;
  assign bus.go_rx_crc_o         = go_rx_crc_q;
  assign bus.go_rx_crc_lim_o     = go_rx_crc_lim_q;
  assign bus.dlc_o               = dlc_q;
  assign bus.data_len_o          = data_len_q;
  assign bus.data_byte_o         = data_byte_q;
  assign bus.data_byte_idx_o     = data_byte_idx_q;
  assign bus.data_byte_valid_o   = data_byte_valid_q;
  assign bus.stuff_count_o       = stuff_count_q;
  assign bus.stuff_parity_err_o  = stuff_parity_err_q;
  assign bus.crc_rx_o            = crc_rx_q;
  assign bus.crc_len_o           = crc_len_q;

endmodule
